uart_cmd_assembler: RTL
=======================

Name: uart_cmd_assembler

Overview:
Downstream consumer of the UART receiver. Takes the receiver's byte output and ready flag, acknowledges each byte with a clear-ready pulse, and packs NUM_BYTES consecutive bytes (MSB first) into one command word. Raises cmd_rdy for the command-processing logic. Discards a partial frame and flags an error if the next byte does not arrive within a timeout.

Parameters:
NUM_BYTES, 2, bytes per command frame (legal range 1..8)
TIMEOUT_CYCLES, 500000, max idle clk cycles between bytes of one frame before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_byte  in  8  byte from UART receiver (valid while rx_rdy=1)
rx_rdy  in  1  receiver has an unconsumed byte
clr_rx_rdy  out  1  combinational 1-cycle ack to receiver, consumes rx_byte
clr_cmd_rdy  in  1  downstream has taken cmd; drop cmd_rdy
cmd  out  8*NUM_BYTES  assembled command, first byte in MS byte
cmd_rdy  out  1  cmd valid and stable
frame_err  out  1  1-cycle pulse: partial frame discarded on timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All flops reset asynchronously on rst=1.
- Reset values: cmd=0, cmd_rdy=0, frame_err=0, state=IDLE, byte_cnt=0, tmo_cnt=0. clr_rx_rdy is combinational and is 0 while rst=1.
- States: IDLE, COLLECT, HOLD (typedef in package).
- accept = rx_rdy & (state==IDLE | state==COLLECT). clr_rx_rdy = accept, in the same cycle. The receiver's ready is a registered flag, so the ack must not be registered; a registered ack would double-consume.
- On accept: cmd <= {cmd[8*NUM_BYTES-9:0], rx_byte}; byte_cnt++; tmo_cnt <= 0.
- IDLE:
  - accept with NUM_BYTES==1 -> HOLD.
  - accept otherwise -> COLLECT.
  - tmo_cnt held at 0.
- COLLECT:
  - accept when byte_cnt==NUM_BYTES-1 -> HOLD, byte_cnt<=0, cmd_rdy<=1 on the same edge as the final shift.
  - no accept -> tmo_cnt++.
  - tmo_cnt==TIMEOUT_CYCLES-1 with no accept -> IDLE, byte_cnt<=0, frame_err<=1 for one cycle. cmd keeps its partial content but cmd_rdy stays 0.
  - Accept wins over timeout in the same cycle.
- HOLD:
  - cmd_rdy=1 and cmd frozen.
  - No accept: backpressure. The byte waits in the receiver, which holds it with rdy=1.
  - clr_cmd_rdy=1 -> IDLE, cmd_rdy<=0. A byte pending in the same cycle is not accepted; it is accepted on the next cycle from IDLE.
- Latency: the final byte's accept cycle is N, and cmd_rdy=1 in cycle N+1.
- clr_cmd_rdy outside HOLD is ignored.
- Timeout counter width is $clog2(TIMEOUT_CYCLES). It never wraps, because it is cleared on abort or accept.
- rst mid-frame: partial bytes are lost and the next byte starts a new frame.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum asm_state_t {IDLE, COLLECT, HOLD}
  - default NUM_BYTES and TIMEOUT_CYCLES localparams
- One natural sub-module: uart_tmo_cnt, a clearable saturating timeout counter with inputs clr and en and output expired. Everything else lives in the top FSM.

Test Plan:
All scenarios use NUM_BYTES=2 and TIMEOUT_CYCLES=20, with a receiver model that holds rx_rdy until clr_rx_rdy.
1. Basic frame: bytes 0xA5 then 0x3C, 5 cycles apart -> exactly one clr_rx_rdy pulse per byte; cmd_rdy=1 one cycle after the second ack; cmd=0xA53C.
2. Backpressure: during HOLD present 0x11 and hold clr_cmd_rdy=0 for 30 cycles -> clr_rx_rdy stays 0 and cmd stays 0xA53C. Then pulse clr_cmd_rdy -> cmd_rdy=0 next cycle and 0x11 accepted one cycle later.
3. Timeout: send 0x55, then nothing for 20 cycles -> frame_err is a single pulse in cycle 20 after the ack; state IDLE; no cmd_rdy. Then 0x01, 0x02 -> cmd=0x0102.
4. Timeout boundary: second byte arrives exactly on cycle 19 (coincident with expiry) -> accepted, cmd_rdy=1, no frame_err.
5. Reset mid-frame: after byte 0x77, assert rst asynchronously (mid-cycle) -> cmd=0 and cmd_rdy=0 immediately. Then 0xDE, 0xAD -> cmd=0xDEAD.
6. Back-to-back frames: 0x12, 0x34, release, then 0x56, 0x78 with clr_cmd_rdy on the first cmd_rdy cycle -> cmd values 0x1234 then 0x5678, with no lost or duplicated bytes.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared types and default parameters for the UART command assembler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } asm_state_t;

    localparam int DEF_NUM_BYTES      = 2;
    localparam int DEF_TIMEOUT_CYCLES = 500000;

endpackage
`default_nettype wire

// File: rtl/uart_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_tmo_cnt
// Purpose  : Clearable saturating idle counter; expired marks the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tmo_cnt #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int                c_w   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_w-1:0]    c_max = c_w'(TIMEOUT_CYCLES - 1);

    logic [c_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + c_w'(1);
        end
    end

    assign expired = (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_assembler
// Purpose  : Packs NUM_BYTES UART bytes (MSB first) into a command word with timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int NUM_BYTES      = DEF_NUM_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_rdy,
    output logic                   clr_rx_rdy,
    input  logic                   clr_cmd_rdy,
    output logic [8*NUM_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    output logic                   frame_err
);

    localparam int                c_cnt_w = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_BYTES - 1);

    asm_state_t             r_state;
    logic [c_cnt_w-1:0]     r_byte_cnt;
    logic                   w_accept;
    logic                   w_expired;
    logic                   w_collect;
    logic [8*NUM_BYTES-1:0] w_cmd_next;

    assign w_collect = (r_state == COLLECT);

    // The receiver's ready is a flop, so the ack must be combinational to avoid a double consume.
    assign w_accept   = rx_rdy && !rst && (r_state == IDLE || w_collect);
    assign clr_rx_rdy = w_accept;

    generate
        if (NUM_BYTES == 1) begin : g_single
            assign w_cmd_next = rx_byte;
        end else begin : g_multi
            assign w_cmd_next = {cmd[8*NUM_BYTES-9:0], rx_byte};
        end
    endgenerate

    uart_tmo_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept || !w_collect || w_expired),
        .en      (w_collect),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
            cmd        <= '0;
            cmd_rdy    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (r_state)
                IDLE, COLLECT: begin
                    if (w_accept) begin
                        cmd <= w_cmd_next;
                        if (r_byte_cnt == c_last) begin
                            r_state    <= HOLD;
                            r_byte_cnt <= '0;
                            cmd_rdy    <= 1'b1;
                        end else begin
                            r_state    <= COLLECT;
                            r_byte_cnt <= r_byte_cnt + c_cnt_w'(1);
                        end
                    end else if (w_collect && w_expired) begin
                        // Partial content stays visible in cmd but is never flagged ready.
                        r_state    <= IDLE;
                        r_byte_cnt <= '0;
                        frame_err  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (clr_cmd_rdy) begin
                        r_state <= IDLE;
                        cmd_rdy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_byte_cnt <= '0;
                    cmd_rdy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
